// File: rtl/clock_pkg.sv
// Shared types, BCD limits and small helpers for the chime clock.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PHRASE,
        ST_GAP,
        ST_STRIKE
    } chime_state_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] HR12_MAX = 8'h12;
    localparam logic [7:0] HR24_MAX = 8'h23;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Number of Westminster phrases for the minute just reached (0 = no chime).
    function automatic logic [2:0] phrases_for_minute(input logic [7:0] mm);
        case (mm)
            8'h15:   return 3'd1;
            8'h30:   return 3'd2;
            8'h45:   return 3'd3;
            8'h00:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Hour strikes in 12-hour terms: 24h values fold mod 12, and 0 strikes twelve.
    function automatic logic [3:0] strikes_for_hour(input logic [7:0] hh, input logic mode24);
        logic [4:0] bin;
        bin = {1'b0, hh[7:4]} * 5'd10 + {1'b0, hh[3:0]};
        if (mode24 && bin >= 5'd12) begin
            bin = bin - 5'd12;
        end
        if (bin == 5'd0) begin
            bin = 5'd12;
        end
        return bin[3:0];
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with synchronous load and a carry on wrap.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = (value_q == MAX) ? 8'h00 : bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/chime_clock.sv
// BCD time-of-day clock (12/24h) with load validation and a Westminster
// quarter-chime sequencer that follows the hour with strikes.
module chime_clock
    import clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 1,
    parameter bit MODE_24H     = 1'b0,
    parameter int NOTE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       load_err,
    output logic       chime,
    output logic [2:0] chime_phrase,
    output logic       strike,
    output logic       chime_busy
);

    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam int CW = $clog2(NOTE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
    localparam logic [CW-1:0] NOTE_LAST  = CW'(NOTE_CYCLES - 1);
    localparam logic [7:0]    HH_RESET   = MODE_24H ? 8'h00 : HR12_MAX;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hh_q, hh_d;
    logic          pm_q, pm_d;
    logic          load_err_q, load_err_d;
    chime_state_e  state_q, state_d;
    logic [2:0]    phrase_q, phrase_d;
    logic [2:0]    nphr_q, nphr_d;
    logic [3:0]    strikes_q, strikes_d;
    logic [CW-1:0] note_q, note_d;

    logic       fields_ok, hh_ok, load_legal;
    logic       tick, advance;
    logic       ss_carry, mm_carry;
    logic [7:0] mm_after;
    logic [2:0] quarter_n;
    logic [3:0] quarter_s;
    logic       trigger;
    logic       note_last;

    // ---------------- load validation and prescaler ----------------
    always_comb begin
        if (MODE_24H) begin
            hh_ok = (load_hh <= HR24_MAX);
        end else begin
            hh_ok = (load_hh >= 8'h01) && (load_hh <= HR12_MAX);
        end
        fields_ok = bcd_valid(load_hh) && bcd_valid(load_mm) && bcd_valid(load_ss)
                    && (load_mm <= SEC_MAX) && (load_ss <= SEC_MAX) && hh_ok;
        load_legal = load && fields_ok;
        load_err_d = load && !fields_ok;
    end

    assign tick    = ena && (presc_q == PRESC_LAST);
    // Any load, even a rejected one, holds the time for that cycle.
    assign advance = tick && !load;

    always_comb begin
        presc_d = presc_q;
        if (load_legal) begin
            presc_d = '0;
        end else if (ena) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // ---------------- seconds / minutes / hours ----------------
    bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
        .clk      (clk),
        .reset    (reset),
        .inc      (advance),
        .load     (load_legal),
        .load_val (load_ss),
        .value    (ss),
        .carry    (ss_carry)
    );

    bcd_mod_counter #(.MAX(SEC_MAX)) u_mm (
        .clk      (clk),
        .reset    (reset),
        .inc      (ss_carry),
        .load     (load_legal),
        .load_val (load_mm),
        .value    (mm),
        .carry    (mm_carry)
    );

    always_comb begin
        hh_d = hh_q;
        pm_d = pm_q;
        if (load_legal) begin
            hh_d = load_hh;
            pm_d = MODE_24H ? (load_hh >= 8'h12) : load_pm;
        end else if (mm_carry) begin
            if (MODE_24H) begin
                hh_d = (hh_q == HR24_MAX) ? 8'h00 : bcd_inc(hh_q);
                pm_d = (hh_d >= 8'h12);
            end else if (hh_q == HR12_MAX) begin
                hh_d = 8'h01;
            end else begin
                hh_d = bcd_inc(hh_q);
                if (hh_q == 8'h11) begin
                    pm_d = !pm_q;
                end
            end
        end
    end

    // ---------------- quarter detection ----------------
    always_comb begin
        if (mm_carry) begin
            mm_after = 8'h00;
        end else if (ss_carry) begin
            mm_after = bcd_inc(mm);
        end else begin
            mm_after = mm;
        end
        quarter_n = phrases_for_minute(mm_after);
        quarter_s = (mm_after == 8'h00) ? strikes_for_hour(hh_d, MODE_24H) : 4'd0;
        trigger   = ss_carry && (quarter_n != 3'd0);
    end

    // ---------------- chime sequencer ----------------
    assign note_last = (note_q == NOTE_LAST);

    always_comb begin
        state_d      = state_q;
        phrase_d     = phrase_q;
        nphr_d       = nphr_q;
        strikes_d    = strikes_q;
        note_d       = note_q;
        chime        = 1'b0;
        chime_phrase = 3'd0;
        strike       = 1'b0;
        chime_busy   = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d   = ST_PHRASE;
                    phrase_d  = 3'd1;
                    nphr_d    = quarter_n;
                    strikes_d = quarter_s;
                    note_d    = '0;
                end
            end
            ST_PHRASE: begin
                chime        = 1'b1;
                chime_phrase = phrase_q;
                note_d       = note_q + CW'(1);
                if (note_last) begin
                    note_d = '0;
                    if (phrase_q < nphr_q) begin
                        state_d = ST_GAP;
                    end else if (strikes_q != 4'd0) begin
                        state_d = ST_STRIKE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                note_d = note_q + CW'(1);
                if (note_last) begin
                    note_d   = '0;
                    phrase_d = phrase_q + 3'd1;
                    state_d  = ST_PHRASE;
                end
            end
            ST_STRIKE: begin
                strike = (note_q == '0);
                note_d = note_q + CW'(1);
                if (note_last) begin
                    note_d    = '0;
                    strikes_d = strikes_q - 4'd1;
                    if (strikes_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A successful time set silences whatever is sounding.
        if (load_legal) begin
            state_d = ST_IDLE;
            note_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            hh_q       <= HH_RESET;
            pm_q       <= 1'b0;
            load_err_q <= 1'b0;
            state_q    <= ST_IDLE;
            phrase_q   <= 3'd0;
            nphr_q     <= 3'd0;
            strikes_q  <= 4'd0;
            note_q     <= '0;
        end else begin
            presc_q    <= presc_d;
            hh_q       <= hh_d;
            pm_q       <= pm_d;
            load_err_q <= load_err_d;
            state_q    <= state_d;
            phrase_q   <= phrase_d;
            nphr_q     <= nphr_d;
            strikes_q  <= strikes_d;
            note_q     <= note_d;
        end
    end

    assign hh       = hh_q;
    assign pm       = pm_q;
    assign load_err = load_err_q;

endmodule
